fft8_input_framer: RTL and testbench

Upstream stage of the 8-point pipelined butterfly core. Accepts one real sample per cycle on a valid/ready stream and assembles complete 8-sample frames. Presents each frame in parallel on x0..x7 with a valid/ready handshake, ready to drive the core's x0..x7 inputs. Ping-pong double buffering lets one frame fill while the previous one waits to be consumed.

---
 rtl/fft8_pkg.sv | 13 +
 rtl/fft8_frame_bank.sv | 30 +++
 rtl/fft8_input_framer.sv | 109 ++++++++++
 tb/tb_fft8_input_framer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft8_pkg.sv
// Shared constants and lane-ordering helper for the 8-point FFT datapath.
package fft8_pkg;

  localparam int N_POINTS = 8;
  localparam int IDX_W    = 3;
  localparam int SAMPLE_W = 8;

  // Reverse the three bits of a sample index (decimation-in-time ordering).
  function automatic logic [IDX_W-1:0] bitrev3(input logic [IDX_W-1:0] n);
    return {n[0], n[1], n[2]};
  endfunction

endpackage

// File: rtl/fft8_frame_bank.sv
// One 8-lane sample register bank; written one lane per cycle, read in parallel.
module fft8_frame_bank
  import fft8_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      we,
  input  logic [IDX_W-1:0]          addr,
  input  logic [WIDTH-1:0]          wdata,
  output logic [N_POINTS*WIDTH-1:0] lanes
);

  logic [WIDTH-1:0] mem [N_POINTS];

  // Lane storage: cleared by reset, otherwise written at the addressed lane.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_POINTS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  for (genvar g = 0; g < N_POINTS; g++) begin : g_lane
    assign lanes[g*WIDTH +: WIDTH] = mem[g];
  end

endmodule

// File: rtl/fft8_input_framer.sv
// Serial-to-parallel framer: assembles 8-sample frames into ping-pong banks
// and presents the oldest complete frame on x0..x7 with valid/ready.
module fft8_input_framer
  import fft8_pkg::*;
#(
  parameter int WIDTH       = SAMPLE_W,
  parameter bit BIT_REVERSE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_sof,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic [WIDTH-1:0] x0,
  output logic [WIDTH-1:0] x1,
  output logic [WIDTH-1:0] x2,
  output logic [WIDTH-1:0] x3,
  output logic [WIDTH-1:0] x4,
  output logic [WIDTH-1:0] x5,
  output logic [WIDTH-1:0] x6,
  output logic [WIDTH-1:0] x7,
  output logic [7:0]       frame_count,
  output logic             sync_err
);

  logic [1:0]                full;
  logic                      wr_bank;
  logic                      rd_bank;
  logic [IDX_W-1:0]          idx;
  logic [IDX_W-1:0]          wr_idx;
  logic [IDX_W-1:0]          lane;
  logic                      accept;
  logic                      consume;
  logic                      resync;
  logic                      complete;
  logic [1:0]                set_full;
  logic [1:0]                clr_full;
  logic [N_POINTS*WIDTH-1:0] lanes_0;
  logic [N_POINTS*WIDTH-1:0] lanes_1;
  logic [N_POINTS*WIDTH-1:0] rd_lanes;

  assign s_ready     = ~full[wr_bank];
  assign frame_valid = full[rd_bank];
  assign accept      = s_valid & s_ready;
  assign consume     = frame_valid & frame_ready;

  // A start-of-frame mid-frame restarts the frame: the sample lands at index 0.
  assign resync   = accept & s_sof & (idx != '0);
  assign wr_idx   = resync ? '0 : idx;
  assign lane     = BIT_REVERSE ? bitrev3(wr_idx) : wr_idx;
  assign complete = accept & ~resync & (idx == 3'd7);

  // Fill and drain always target different banks, so set and clear never collide.
  assign set_full = complete ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
  assign clr_full = consume  ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;

  fft8_frame_bank #(.WIDTH(WIDTH)) u_bank_0 (
    .clk   (clk),
    .reset (reset),
    .we    (accept & ~wr_bank),
    .addr  (lane),
    .wdata (s_data),
    .lanes (lanes_0)
  );

  fft8_frame_bank #(.WIDTH(WIDTH)) u_bank_1 (
    .clk   (clk),
    .reset (reset),
    .we    (accept & wr_bank),
    .addr  (lane),
    .wdata (s_data),
    .lanes (lanes_1)
  );

  // Control state: sample index, bank pointers, full flags, counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full        <= 2'b00;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      idx         <= '0;
      frame_count <= 8'd0;
      sync_err    <= 1'b0;
    end else begin
      full     <= (full & ~clr_full) | set_full;
      sync_err <= resync;
      if (accept) idx <= resync ? 3'd1 : idx + 3'd1;
      if (complete) wr_bank <= ~wr_bank;
      if (consume) begin
        rd_bank     <= ~rd_bank;
        frame_count <= frame_count + 8'd1;
      end
    end
  end

  assign rd_lanes = rd_bank ? lanes_1 : lanes_0;
  assign x0 = rd_lanes[0*WIDTH +: WIDTH];
  assign x1 = rd_lanes[1*WIDTH +: WIDTH];
  assign x2 = rd_lanes[2*WIDTH +: WIDTH];
  assign x3 = rd_lanes[3*WIDTH +: WIDTH];
  assign x4 = rd_lanes[4*WIDTH +: WIDTH];
  assign x5 = rd_lanes[5*WIDTH +: WIDTH];
  assign x6 = rd_lanes[6*WIDTH +: WIDTH];
  assign x7 = rd_lanes[7*WIDTH +: WIDTH];

endmodule

// File: tb/tb_fft8_input_framer.sv
// Self-checking bench: natural-order and bit-reversed framers driven in
// parallel, compared against a queue-based frame model.
module tb_fft8_input_framer;

  typedef logic [7:0] frame_t [8];

  logic       clk = 1'b0;
  logic       reset;
  logic       s_valid, s_sof, frame_ready;
  logic [7:0] s_data;

  logic       a_ready, a_valid, a_sync;
  logic       b_ready, b_valid, b_sync;
  logic [7:0] a_x [8];
  logic [7:0] b_x [8];
  logic [7:0] a_count, b_count;

  int tests = 0;
  int fails = 0;

  // reference model state
  frame_t     fq [$];
  logic [7:0] part [$];
  logic [7:0] fcount;
  logic       exp_sync;
  int         rev_tab [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  always #5 clk = ~clk;

  fft8_input_framer #(.WIDTH(8), .BIT_REVERSE(1'b0)) dut_a (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(a_ready),
    .s_data(s_data), .s_sof(s_sof), .frame_valid(a_valid), .frame_ready(frame_ready),
    .x0(a_x[0]), .x1(a_x[1]), .x2(a_x[2]), .x3(a_x[3]),
    .x4(a_x[4]), .x5(a_x[5]), .x6(a_x[6]), .x7(a_x[7]),
    .frame_count(a_count), .sync_err(a_sync)
  );

  fft8_input_framer #(.WIDTH(8), .BIT_REVERSE(1'b1)) dut_b (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(b_ready),
    .s_data(s_data), .s_sof(s_sof), .frame_valid(b_valid), .frame_ready(frame_ready),
    .x0(b_x[0]), .x1(b_x[1]), .x2(b_x[2]), .x3(b_x[3]),
    .x4(b_x[4]), .x5(b_x[5]), .x6(b_x[6]), .x7(b_x[7]),
    .frame_count(b_count), .sync_err(b_sync)
  );

  function automatic logic [63:0] pack(input logic [7:0] v [8]);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = v[i];
    return r;
  endfunction

  function automatic logic [63:0] pack_list(input int v [8]);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = v[i][7:0];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic        ev;
    logic [63:0] ea, eb;
    ev = (fq.size() > 0);
    chk("a_s_ready",     {63'd0, a_ready}, {63'd0, fq.size() < 2});
    chk("b_s_ready",     {63'd0, b_ready}, {63'd0, fq.size() < 2});
    chk("a_frame_valid", {63'd0, a_valid}, {63'd0, ev});
    chk("b_frame_valid", {63'd0, b_valid}, {63'd0, ev});
    chk("a_sync_err",    {63'd0, a_sync},  {63'd0, exp_sync});
    chk("b_sync_err",    {63'd0, b_sync},  {63'd0, exp_sync});
    chk("a_frame_count", {56'd0, a_count}, {56'd0, fcount});
    chk("b_frame_count", {56'd0, b_count}, {56'd0, fcount});
    if (ev) begin
      ea = '0; eb = '0;
      for (int n = 0; n < 8; n++) begin
        ea[8*n +: 8]          = fq[0][n];
        eb[8*rev_tab[n] +: 8] = fq[0][n];
      end
      chk("a_lanes", pack(a_x), ea);
      chk("b_lanes", pack(b_x), eb);
    end
  endtask

  // One clock: drive, advance the model on the edge, check just after it.
  task automatic step(input logic v, input logic [7:0] d, input logic sof,
                      input logic fr, output logic acc);
    logic   cons, rs;
    frame_t f;
    s_valid = v; s_data = d; s_sof = sof; frame_ready = fr;
    acc  = v && (fq.size() < 2);
    cons = (fq.size() > 0) && fr;
    rs   = 1'b0;
    @(posedge clk);
    if (cons) begin
      fq.delete(0);
      fcount = fcount + 8'd1;
    end
    if (acc) begin
      if (sof && part.size() != 0) begin
        part.delete();
        rs = 1'b1;
      end
      part.push_back(d);
      if (part.size() == 8) begin
        for (int i = 0; i < 8; i++) f[i] = part[i];
        fq.push_back(f);
        part.delete();
      end
    end
    exp_sync = rs;
    #1;
    check_outputs();
  endtask

  task automatic model_reset();
    fq.delete();
    part.delete();
    fcount   = 8'd0;
    exp_sync = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_a_valid"}, {63'd0, a_valid}, 64'd0);
    chk({tag, "_b_valid"}, {63'd0, b_valid}, 64'd0);
    chk({tag, "_a_lanes"}, pack(a_x), 64'd0);
    chk({tag, "_b_lanes"}, pack(b_x), 64'd0);
    chk({tag, "_a_count"}, {56'd0, a_count}, 64'd0);
    chk({tag, "_a_ready"}, {63'd0, a_ready}, 64'd1);
    chk({tag, "_a_sync"},  {63'd0, a_sync},  64'd0);
  endtask

  initial begin
    logic        acc;
    int          stream [8] = '{82, 44, 62, 79, 92, 74, 18, 41};
    int          brev   [8] = '{82, 92, 62, 18, 44, 74, 79, 41};
    int          resy   [8] = '{100, 101, 102, 103, 104, 105, 106, 107};
    int          pulses, last_pulse, cyc, syncs, tries;
    logic [7:0]  cnt0;

    reset = 1'b1; s_valid = 1'b0; s_data = '0; s_sof = 1'b0; frame_ready = 1'b0;
    model_reset();
    #3;
    check_reset_state("in_reset");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_reset_state("after_reset");

    // single frame, natural and bit-reversed lanes
    for (int i = 0; i < 8; i++) step(1'b1, stream[i][7:0], 1'b0, 1'b1, acc);
    chk("single_a_lanes", pack(a_x), pack_list(stream));
    chk("single_b_lanes", pack(b_x), pack_list(brev));
    step(1'b0, 8'd0, 1'b0, 1'b1, acc);
    chk("single_valid_one_cycle", {63'd0, a_valid}, 64'd0);
    chk("single_count", {56'd0, a_count}, 64'd1);

    // backpressure: two frames fill, third waits
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, acc);
    chk("bp_ready_low", {63'd0, a_ready}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'd16, 1'b0, 1'b0, acc);
      chk("bp_held_lanes", pack(a_x), 64'h0706050403020100);
    end
    step(1'b1, 8'd16, 1'b0, 1'b1, acc);
    chk("bp_no_accept_when_full", {63'd0, acc}, 64'd0);
    chk("bp_second_frame", pack(a_x), 64'h0f0e0d0c0b0a0908);
    chk("bp_ready_back", {63'd0, a_ready}, 64'd1);
    for (int i = 16; i < 24; i++) begin
      tries = 0;
      do begin
        step(1'b1, 8'(i), 1'b0, 1'b0, acc);
        tries++;
      end while (!acc && tries < 20);
      if (!acc) chk("bp_accept_timeout", 64'd0, 64'd1);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 8'd0, 1'b0, 1'b1, acc);

    // continuous stream, random data
    cnt0 = a_count; pulses = 0; last_pulse = -100; cyc = 0;
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 8'($urandom), 1'b0, 1'b1, acc);
      cyc++;
      if (a_valid) begin
        if (pulses > 0) chk("cont_spacing", 64'(cyc - last_pulse), 64'd8);
        pulses++;
        last_pulse = cyc;
      end
    end
    step(1'b0, 8'd0, 1'b0, 1'b1, acc);
    chk("cont_pulses", 64'(pulses), 64'd8);
    chk("cont_count_delta", {56'd0, 8'(a_count - cnt0)}, 64'd8);

    // resync mid-frame
    syncs = 0;
    for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b0, 1'b0, acc);
    step(1'b1, 8'd100, 1'b1, 1'b0, acc);
    if (a_sync) syncs++;
    for (int i = 101; i <= 107; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0, acc);
      if (a_sync) syncs++;
    end
    chk("resync_pulses", 64'(syncs), 64'd1);
    chk("resync_lanes", pack(a_x), pack_list(resy));
    step(1'b0, 8'd0, 1'b0, 1'b1, acc);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 19) == 0,
           $urandom_range(0, 1) == 1, acc);

    // drain, realign, then reset with one full bank and idx=3
    for (int i = 0; i < 3; i++) step(1'b0, 8'd0, 1'b0, 1'b1, acc);
    step(1'b1, 8'd200, 1'b1, 1'b0, acc);
    for (int i = 1; i < 11; i++) step(1'b1, 8'(200 + i), 1'b0, 1'b0, acc);
    chk("pre_reset_valid", {63'd0, a_valid}, 64'd1);
    reset = 1'b1;
    model_reset();
    #2;
    check_reset_state("mid_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_outputs();
    for (int i = 0; i < 8; i++) step(1'b1, 8'(50 + i), 1'b0, 1'b0, acc);
    chk("post_reset_frame", pack(a_x), 64'h3938373635343332);
    step(1'b0, 8'd0, 1'b0, 1'b1, acc);
    chk("post_reset_count", {56'd0, a_count}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
